// File: rtl/updowncounter_sequencer_if.sv
// Command, status and counter-control bundle for the up/down counter sweep sequencer.
interface updowncounter_sequencer_if #(
  parameter int WIDTH  = 6,
  parameter int PASS_W = 4
);
  // Command side
  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [PASS_W-1:0] passes;
  // Status side
  logic              busy;
  logic              done;
  logic              err;
  logic [PASS_W-1:0] pass_cnt;
  logic              dir;
  // Counter control and feedback
  logic              ctr_load;
  logic [WIDTH-1:0]  ctr_data;
  logic              ctr_count_up;
  logic [WIDTH-1:0]  ctr_count;

  // Issues commands, observes status and models/feeds the counter
  modport master (
    output start, stop, lo, hi, passes, ctr_count,
    input  busy, done, err, pass_cnt, dir, ctr_load, ctr_data, ctr_count_up
  );

  // The sequencer itself
  modport slave (
    input  start, stop, lo, hi, passes, ctr_count,
    output busy, done, err, pass_cnt, dir, ctr_load, ctr_data, ctr_count_up
  );
endinterface

// File: rtl/updowncounter_sequencer.sv
// Triangle-sweep controller for a free-running 6-bit up/down counter.
// Loads LO, counts up to HI, down to LO, and repeats for a programmed number
// of passes. The counter always moves unless loaded, so every non-sweeping
// state parks it at lo_q by holding LOAD high.
module updowncounter_sequencer #(
  parameter int WIDTH  = 6,
  parameter int PASS_W = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  updowncounter_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_UP   = 3'd2;
  localparam logic [2:0] ST_DOWN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              err_q, err_d;

  logic              cfg_ok;
  logic              track_err;
  logic [WIDTH-1:0]  hi_m1;
  logic [WIDTH-1:0]  lo_p1;
  logic [PASS_W-1:0] pass_inc;
  logic              last_pass;

  // A config is usable only with a non-empty range and at least one pass;
  // LO < HI also guarantees hi_q-1 and lo_q+1 never wrap.
  assign cfg_ok    = (bus.lo < bus.hi) && (bus.passes != '0);
  // Counter outside the latched window means someone else moved it.
  assign track_err = (bus.ctr_count < lo_q) || (bus.ctr_count > hi_q);
  // Turn around one count early: the counter lands on the bound the same edge.
  assign hi_m1     = hi_q - WIDTH'(1);
  assign lo_p1     = lo_q + WIDTH'(1);
  assign pass_inc  = pass_cnt_q + PASS_W'(1);
  assign last_pass = (pass_inc == passes_q);

  // Next-state logic: command handling, turnarounds, abort and tracking check.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // STOP in the same cycle suppresses START entirely.
        if (bus.start && !bus.stop) begin
          if (cfg_ok) begin
            lo_d       = bus.lo;
            hi_d       = bus.hi;
            passes_d   = bus.passes;
            pass_cnt_d = '0;
            state_d    = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (bus.stop) state_d = ST_IDLE;
        else          state_d = ST_UP;
      end
      ST_UP: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (track_err) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.ctr_count == hi_m1) begin
          state_d = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (track_err) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.ctr_count == lo_p1) begin
          pass_cnt_d = pass_inc;
          state_d    = last_pass ? ST_DONE : ST_UP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and configuration registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
    end
  end

  // Status and counter-control decode, purely from the current state.
  assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_UP) || (state_q == ST_DOWN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.err          = err_q;
  assign bus.pass_cnt     = pass_cnt_q;
  assign bus.dir          = (state_q == ST_UP);
  assign bus.ctr_load     = !((state_q == ST_UP) || (state_q == ST_DOWN));
  assign bus.ctr_count_up = (state_q == ST_UP);
  assign bus.ctr_data     = lo_q;

endmodule

// File: doc/updowncounter_sequencer.md
# updowncounter_sequencer

Sweep controller for the 6-bit up/down counter. It drives the counter's LOAD, DATA and COUNT_UP inputs to run a programmed number of triangle passes: load LO, count up to HI, count down to LO, then repeat. It watches COUNT to decide each turnaround. Control comes from a START/STOP command interface with BUSY, DONE and ERR status.

## Interface
- WIDTH, 6, counter data width; must match the counter instance.
- PASS_W, 4, width of the pass-count field.
- CLK  in  1  clock; the counter instance is on the same clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  command pulse; sampled only in IDLE.
- STOP  in  1  abort; sampled in every state.
- LO  in  WIDTH  sweep lower bound; latched on START.
- HI  in  WIDTH  sweep upper bound; latched on START.
- PASSES  in  PASS_W  number of LO→HI→LO passes; latched on START.
- BUSY  out  1  high in states LOAD, UP and DOWN.
- DONE  out  1  one-cycle pulse when the last pass completes.
- ERR  out  1  one-cycle pulse on a config error or a tracking error.
- PASS_CNT  out  PASS_W  number of passes completed in the current or last run.
- DIR  out  1  1 in state UP, else 0.
- CTR_LOAD  out  1  drives the counter's LOAD.
- CTR_DATA  out  WIDTH  drives the counter's DATA; always equals lo_q.
- CTR_COUNT_UP  out  1  drives the counter's COUNT_UP.
- CTR_COUNT  in  WIDTH  the counter's COUNT.

## Operation
- Counter contract:
  - Registered on CLK.
  - LOAD has priority and sets COUNT to DATA.
  - Otherwise COUNT moves ±1 every cycle, +1 when COUNT_UP=1 and −1 when COUNT_UP=0.
  - The counter never holds on its own, so the sequencer parks it by holding CTR_LOAD=1.
- Internal registers:
  - lo_q, hi_q, passes_q: the latched configuration.
  - pass_cnt.
  - state: IDLE, LOAD, UP, DOWN, DONE.
- Output decode by state:
  - IDLE, LOAD, DONE: CTR_LOAD=1, CTR_COUNT_UP=0. The counter parks at lo_q.
  - UP: CTR_LOAD=0, CTR_COUNT_UP=1.
  - DOWN: CTR_LOAD=0, CTR_COUNT_UP=0.
- Transitions:
  - IDLE with START=1 and STOP=0:
    - If LO < HI and PASSES ≠ 0: latch the config, clear pass_cnt, go to LOAD.
    - Otherwise: pulse ERR, stay in IDLE, leave the latched config unchanged.
  - LOAD → UP unconditionally.
  - UP with CTR_COUNT == hi_q−1 → DOWN. The counter reaches hi_q on the same edge.
  - DOWN with CTR_COUNT == lo_q+1: pass_cnt increments.
    - If pass_cnt+1 == passes_q → DONE.
    - Otherwise → UP.
  - DONE → IDLE after exactly one cycle. DONE=1 only while in the DONE state.
- Tracking check:
  - Applies in UP or DOWN.
  - Trigger: CTR_COUNT < lo_q or CTR_COUNT > hi_q, e.g. the counter was reset externally.
  - Response: ERR pulse, go to IDLE, no DONE.
- STOP in LOAD, UP or DOWN:
  - Go to IDLE next edge; the counter is reloaded to lo_q one edge later.
  - No DONE; pass_cnt keeps its value.
- START and STOP in the same IDLE cycle: STOP wins and START is ignored.
- START while BUSY or in DONE: ignored.
- Arithmetic:
  - Comparisons are unsigned.
  - hi_q−1 and lo_q+1 cannot wrap, because LO < HI is enforced.
  - HI = LO+1 is legal: the counter alternates LO, HI each cycle.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, ERR=0, PASS_CNT=0, DIR=0, CTR_LOAD=1, CTR_COUNT_UP=0, lo_q=hi_q=passes_q=0, so CTR_DATA=0.
- Reset mid-run: immediate return to IDLE with the values above. The counter is forced to 0 at the next edge via LOAD.
- Cycle timeline, with edge 0 the edge that samples START:
  - Edge 1: COUNT=LO.
  - Edge 1+k: COUNT=LO+k while rising.
- One pass takes 2·(HI−LO) edges.
- Last return to LO: edge 1 + PASSES·2·(HI−LO). DONE is high in the cycle after that edge.
- BUSY rises the cycle after the START edge and falls in the cycle DONE is high.
- ERR for a config error is high in the cycle after the START edge.

## Test plan
- LO=10, HI=13, PASSES=2, START → COUNT sequence 10,11,12,13,12,11,10,11,12,13,12,11,10 on edges 1–13. DONE pulses once after edge 13, PASS_CNT=2, and COUNT then holds at 10.
- LO=5, HI=6, PASSES=3 → COUNT alternates 5,6 from edge 1. DONE after edge 7, then COUNT holds at 5.
- LO=20, HI=20, START → ERR one cycle, BUSY stays 0, CTR_DATA unchanged. A repeat with PASSES=0 and LO<HI gives the same response.
- LO=0, HI=63, PASSES=1, STOP at edge 30 → IDLE next edge, no DONE, COUNT=0 one edge later. A START during the run has no effect.
- Run LO=8, HI=12, then pulse the counter's own RESET so COUNT=0 → ERR pulse, IDLE, BUSY=0.
- Deassert RESET_N mid-DOWN → all outputs at reset values immediately. After release, START with LO=1, HI=3, PASSES=1 completes with DONE after edge 5.
